// File: rtl/gpi_pad_ctrl.sv
// ---------------------------------------------------------------------------
// gpi_pad_ctrl
//
// Controller for a bank of general-purpose input pad cells.
//
// Each pad has its own small state machine:
//   OFF    -> pad input buffer disabled; level and debounce state cleared.
//   SETTLE -> input buffer enabled and waiting SETTLE_CYC cycles for the
//             pad receiver to settle before its samples are trusted.
//   ACTIVE -> samples are debounced into LVL_O.
//             Qualified rising and falling edges set sticky status bits.
//
// The raw pad input passes through a 2-flop synchroniser. The synchroniser
// keeps running while the pad is disabled, so it already holds a clean
// sample when the pad comes out of SETTLE.
//
// Parameters
//   N_PADS     number of pad cells controlled
//   SETTLE_CYC cycles IE_O must be high before VLD_O rises (1..255)
//   DEB_W      width of the debounce threshold and debounce counters
//
// Ports
//   CLK_I       clock, rising edge
//   RST_I       asynchronous active-high reset
//   EN_I        per-pad enable
//   STE_CFG_I   Schmitt-trigger setting, copied to every pad
//   DEB_THR_I   debounce threshold in cycles (0 is treated as 1)
//   IRQ_MASK_I  interrupt mask; bit 2i = rise of pad i, bit 2i+1 = fall
//   CLR_I       write-1-to-clear strobe for STS_O (same bit map)
//   PAD_DI_I    raw pad data, asynchronous to CLK_I
//   IE_O        pad input enable
//   STE_O       pad Schmitt-trigger enable, bits [2i+1:2i] for pad i
//   LVL_O       debounced pad level
//   VLD_O       pad is ACTIVE
//   STS_O       sticky edge status (same bit map as IRQ_MASK_I)
//   IRQ_O       registered OR of STS_O & IRQ_MASK_I
// ---------------------------------------------------------------------------
module gpi_pad_ctrl #(
  parameter int unsigned N_PADS     = 8,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned DEB_W      = 8
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic [N_PADS-1:0]     EN_I,
  input  logic [1:0]            STE_CFG_I,
  input  logic [DEB_W-1:0]      DEB_THR_I,
  input  logic [2*N_PADS-1:0]   IRQ_MASK_I,
  input  logic [2*N_PADS-1:0]   CLR_I,
  input  logic [N_PADS-1:0]     PAD_DI_I,
  output logic [N_PADS-1:0]     IE_O,
  output logic [2*N_PADS-1:0]   STE_O,
  output logic [N_PADS-1:0]     LVL_O,
  output logic [N_PADS-1:0]     VLD_O,
  output logic [2*N_PADS-1:0]   STS_O,
  output logic                  IRQ_O
);

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC);

  // A threshold of 0 is treated as 1 so that every mismatch still needs at
  // least one compare cycle before the level flips.
  logic [DEB_W-1:0] thr_eff;
  assign thr_eff = (DEB_THR_I == '0) ? DEB_W'(1) : DEB_THR_I;

  // -------------------------------------------------------------------------
  // Schmitt-trigger configuration: registered and fanned out to every pad,
  // independent of pad state.
  // -------------------------------------------------------------------------
  logic [2*N_PADS-1:0] ste_q;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ste_q <= '0;
    end else begin
      ste_q <= {N_PADS{STE_CFG_I}};
    end
  end

  assign STE_O = ste_q;

  // -------------------------------------------------------------------------
  // Per-pad logic
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_PADS; gi++) begin : g_pad
    logic             sync1_q;
    logic             sync2_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [7:0]       settle_q;
    logic [7:0]       settle_d;
    logic [DEB_W-1:0] deb_q;
    logic [DEB_W-1:0] deb_d;
    logic [DEB_W:0]   deb_inc;
    logic             lvl_q;
    logic             lvl_d;
    logic [1:0]       sts_q;
    logic [1:0]       sts_d;
    logic [1:0]       set_edge;

    // Synchroniser: cleared only by RST_I, never by EN_I.
    always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= PAD_DI_I[gi];
        sync2_q <= sync1_q;
      end
    end

    // One bit wider than the counter so the compare against the threshold
    // cannot overflow when the counter is near its maximum.
    assign deb_inc = {1'b0, deb_q} + {{DEB_W{1'b0}}, 1'b1};

    always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      deb_d    = deb_q;
      lvl_d    = lvl_q;
      set_edge = 2'b00;

      if (!EN_I[gi]) begin
        // Dropping the enable wins from any state; status is kept.
        state_d  = ST_OFF;
        settle_d = '0;
        deb_d    = '0;
        lvl_d    = 1'b0;
      end else begin
        case (state_q)
          ST_OFF: begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_LOAD;
          end

          ST_SETTLE: begin
            // Leave on the edge where the counter reads 1, giving exactly
            // SETTLE_CYC cycles of IE_O before VLD_O. The initial level is
            // taken as-is and does not count as an edge.
            if (settle_q <= 8'd1) begin
              state_d  = ST_ACTIVE;
              settle_d = '0;
              lvl_d    = sync2_q;
            end else begin
              settle_d = settle_q - 8'd1;
            end
          end

          ST_ACTIVE: begin
            if (sync2_q != lvl_q) begin
              // This cycle is mismatch number deb_q+1; flip when it reaches
              // the threshold currently presented.
              if (deb_inc >= {1'b0, thr_eff}) begin
                lvl_d    = sync2_q;
                deb_d    = '0;
                set_edge = sync2_q ? 2'b01 : 2'b10;
              end else if (deb_q != '1) begin
                deb_d = deb_inc[DEB_W-1:0];
              end
            end else begin
              deb_d = '0;
            end
          end

          default: begin
            state_d  = ST_OFF;
            settle_d = '0;
            deb_d    = '0;
            lvl_d    = 1'b0;
          end
        endcase
      end

      // A new edge in the same cycle as a clear strobe keeps the bit set.
      sts_d = (sts_q & ~CLR_I[2*gi +: 2]) | set_edge;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
        state_q  <= ST_OFF;
        settle_q <= '0;
        deb_q    <= '0;
        lvl_q    <= 1'b0;
        sts_q    <= 2'b00;
      end else begin
        state_q  <= state_d;
        settle_q <= settle_d;
        deb_q    <= deb_d;
        lvl_q    <= lvl_d;
        sts_q    <= sts_d;
      end
    end

    assign IE_O[gi]         = (state_q != ST_OFF);
    assign VLD_O[gi]        = (state_q == ST_ACTIVE);
    assign LVL_O[gi]        = lvl_q;
    assign STS_O[2*gi +: 2] = sts_q;
  end

  // -------------------------------------------------------------------------
  // Interrupt: registered, so it follows STS_O or the mask by one cycle.
  // -------------------------------------------------------------------------
  logic irq_q;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(STS_O & IRQ_MASK_I);
    end
  end

  assign IRQ_O = irq_q;

endmodule

// File: tb/tb_gpi_pad_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for gpi_pad_ctrl.
// Directed scenarios followed by a randomized run. The randomized run is
// compared against a cycle-level behavioural model of the pad rules.
// ---------------------------------------------------------------------------
module tb_gpi_pad_ctrl;

  localparam int N  = 8;
  localparam int SC = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    en;
  logic [1:0]      ste_cfg;
  logic [DW-1:0]   deb_thr;
  logic [2*N-1:0]  irq_mask;
  logic [2*N-1:0]  clr;
  logic [N-1:0]    pad;
  logic [N-1:0]    ie;
  logic [2*N-1:0]  ste;
  logic [N-1:0]    lvl;
  logic [N-1:0]    vld;
  logic [2*N-1:0]  sts;
  logic            irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpi_pad_ctrl #(.N_PADS(N), .SETTLE_CYC(SC), .DEB_W(DW)) dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .EN_I       (en),
    .STE_CFG_I  (ste_cfg),
    .DEB_THR_I  (deb_thr),
    .IRQ_MASK_I (irq_mask),
    .CLR_I      (clr),
    .PAD_DI_I   (pad),
    .IE_O       (ie),
    .STE_O      (ste),
    .LVL_O      (lvl),
    .VLD_O      (vld),
    .STS_O      (sts),
    .IRQ_O      (irq)
  );

  // ---------------- behavioural model ----------------
  // en_age: consecutive enabled edges, capped at SC+1 (SC+1 means ACTIVE).
  // run:    consecutive compare cycles in which the sample disagreed.
  // d1/d2:  pad value seen one and two edges ago.
  int             en_age [N];
  int             run    [N];
  logic           m_lvl  [N];
  logic           d1     [N];
  logic           d2     [N];
  logic [2*N-1:0] m_sts;
  logic [2*N-1:0] m_ste;
  logic           m_irq;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      en_age[i] = 0; run[i] = 0; m_lvl[i] = 1'b0; d1[i] = 1'b0; d2[i] = 1'b0;
    end
    m_sts = '0; m_ste = '0; m_irq = 1'b0;
  endtask

  task automatic model_edge();
    logic [2*N-1:0] set_v;
    logic           next_irq;
    logic           sample;
    int             thr;
    set_v    = '0;
    thr      = (deb_thr == 0) ? 1 : int'(deb_thr);
    next_irq = |(m_sts & irq_mask);
    for (int i = 0; i < N; i++) begin
      sample = d2[i];
      if (!en[i]) begin
        en_age[i] = 0; run[i] = 0; m_lvl[i] = 1'b0;
      end else begin
        if (en_age[i] > SC) begin
          if (sample != m_lvl[i]) begin
            run[i]++;
            if (run[i] >= thr) begin
              m_lvl[i] = sample;
              run[i]   = 0;
              if (sample) set_v[2*i] = 1'b1;
              else        set_v[2*i+1] = 1'b1;
            end
          end else begin
            run[i] = 0;
          end
        end else if (en_age[i] == SC) begin
          m_lvl[i] = sample;
        end
        if (en_age[i] <= SC) en_age[i]++;
      end
      d2[i] = d1[i];
      d1[i] = pad[i];
    end
    m_sts = (m_sts & ~clr) | set_v;
    m_ste = {N{ste_cfg}};
    m_irq = next_irq;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en = '0; ste_cfg = 2'b10; deb_thr = 8'd3;
    irq_mask = '0; clr = '0; pad = '0;
    model_reset();
    #12;
    checks++;
    if ({ie, vld, lvl, sts, ste, irq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ie=%h vld=%h lvl=%h sts=%h ste=%h irq=%b expected all 0",
               ie, vld, lvl, sts, ste, irq);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (ie !== '0 || vld !== '0) begin
      errors++;
      $display("FAIL reset_release_idle ie=%h vld=%h expected 0", ie, vld);
    end
    checks++;
    if (ste !== {N{2'b10}}) begin
      errors++;
      $display("FAIL ste_fanout ste=%h expected %h", ste, {N{2'b10}});
    end
    $display("test_reset done");
  endtask

  task automatic test_settle();
    en = 8'h01;
    for (int k = 0; k <= SC; k++) begin
      step();
      checks++;
      if (ie[0] !== 1'b1 || vld[0] !== (k == SC) || sts !== '0) begin
        errors++;
        $display("FAIL settle_k%0d ie0=%b vld0=%b sts=%h expected ie0=1 vld0=%b sts=0",
                 k, ie[0], vld[0], sts, (k == SC));
      end
    end
    $display("test_settle done");
  endtask

  task automatic test_debounce();
    deb_thr = 8'd3; irq_mask = 16'h0001;
    pad[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (lvl[0] !== (k == 5)) begin
        errors++;
        $display("FAIL debounce_lvl_k%0d lvl0=%b expected %b", k, lvl[0], (k == 5));
      end
    end
    checks++;
    if (sts[0] !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL debounce_sts sts=%h irq=%b expected sts[0]=1 irq=0", sts, irq);
    end
    step();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL debounce_irq irq=%b expected 1", irq);
    end
    $display("test_debounce done");
  endtask

  task automatic test_glitch();
    pad[0] = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (lvl[0] !== 1'b0 || sts[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL fall_detect lvl0=%b sts=%h expected lvl0=0 sts[1:0]=11", lvl[0], sts);
    end
    clr = '1;
    step();
    clr = '0;
    checks++;
    if (sts !== '0) begin
      errors++;
      $display("FAIL clear_all sts=%h expected 0", sts);
    end
    pad[0] = 1'b1; step(); step();
    pad[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (lvl[0] !== 1'b0 || sts !== '0) begin
        errors++;
        $display("FAIL glitch_k%0d lvl0=%b sts=%h expected lvl0=0 sts=0", k, lvl[0], sts);
      end
    end
    $display("test_glitch done");
  endtask

  task automatic test_clr_collision();
    pad[0] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    clr = 16'h0001;
    step();
    checks++;
    if (sts[0] !== 1'b1 || lvl[0] !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear sts0=%b lvl0=%b expected 1 1", sts[0], lvl[0]);
    end
    step();
    clr = '0;
    checks++;
    if (sts[0] !== 1'b0) begin
      errors++;
      $display("FAIL plain_clear sts0=%b expected 0", sts[0]);
    end
    $display("test_clr_collision done");
  endtask

  task automatic test_disable();
    logic [2*N-1:0] sts_before;
    pad[0] = 1'b0;
    for (int k = 0; k < 3; k++) step();
    sts_before = m_sts;
    en[0] = 1'b0;
    step();
    checks++;
    if (ie[0] !== 1'b0 || lvl[0] !== 1'b0 || vld[0] !== 1'b0 || sts !== sts_before) begin
      errors++;
      $display("FAIL disable ie0=%b lvl0=%b vld0=%b sts=%h expected 0 0 0 sts=%h",
               ie[0], lvl[0], vld[0], sts, sts_before);
    end
    en[0] = 1'b1;
    for (int k = 0; k <= SC; k++) begin
      step();
      checks++;
      if (ie[0] !== 1'b1 || vld[0] !== (k == SC) || lvl[0] !== 1'b0) begin
        errors++;
        $display("FAIL reenable_k%0d ie0=%b vld0=%b lvl0=%b expected 1 %b 0",
                 k, ie[0], vld[0], lvl[0], (k == SC));
      end
    end
    $display("test_disable done");
  endtask

  task automatic test_async_reset();
    en[0] = 1'b0; step();
    en[0] = 1'b1; step(); step();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({ie, vld, lvl, sts, ste, irq} !== '0) begin
      errors++;
      $display("FAIL async_reset ie=%h vld=%h lvl=%h sts=%h ste=%h irq=%b expected all 0",
               ie, vld, lvl, sts, ste, irq);
    end
    @(posedge clk); @(posedge clk);
    #4;
    rst = 1'b0;
    for (int k = 0; k <= SC; k++) begin
      step();
      checks++;
      if (ie[0] !== 1'b1 || vld[0] !== (k == SC)) begin
        errors++;
        $display("FAIL post_reset_settle_k%0d ie0=%b vld0=%b expected 1 %b",
                 k, ie[0], vld[0], (k == SC));
      end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [N-1:0] exp_ie, exp_vld, exp_lvl;
    en = '1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 4) == 0)  pad[i] = ~pad[i];
      end
      if ($urandom_range(0, 29) == 0) deb_thr = DW'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) irq_mask = 16'($urandom);
      if ($urandom_range(0, 19) == 0) ste_cfg = 2'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : '0;
      step();
      for (int i = 0; i < N; i++) begin
        exp_ie[i]  = (en_age[i] > 0);
        exp_vld[i] = (en_age[i] > SC);
        exp_lvl[i] = m_lvl[i];
      end
      checks++;
      if (ie !== exp_ie || vld !== exp_vld || lvl !== exp_lvl) begin
        errors++;
        $display("FAIL rand_c%0d ie=%h vld=%h lvl=%h expected ie=%h vld=%h lvl=%h",
                 c, ie, vld, lvl, exp_ie, exp_vld, exp_lvl);
      end
      checks++;
      if (sts !== m_sts || irq !== m_irq || ste !== m_ste) begin
        errors++;
        $display("FAIL rand_sts_c%0d sts=%h irq=%b ste=%h expected sts=%h irq=%b ste=%h",
                 c, sts, irq, ste, m_sts, m_irq, m_ste);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_settle();
    test_debounce();
    test_glitch();
    test_clr_collision();
    test_disable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpi_pad_ctrl.md
GPI_PAD_CTRL -- requirements
Module: gpi_pad_ctrl

Interface
REQ-001 SHALL provide parameter N_PADS, default 8, number of GPI pad cells controlled.
REQ-002 SHALL provide parameter SETTLE_CYC, default 4, range 1-255, cycles IE_O must be high before a pad's sample is valid.
REQ-003 SHALL provide parameter DEB_W, default 8, width of the debounce threshold and counters.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: CLK_I in 1 clock (rising edge), RST_I in 1 asynchronous active-high reset.
REQ-005 SHALL have port EN_I in N_PADS, per-pad enable.
REQ-006 SHALL have port STE_CFG_I in 2, Schmitt-trigger setting applied to every pad.
REQ-007 SHALL have port DEB_THR_I in DEB_W, debounce threshold in cycles; 0 behaves as 1.
REQ-008 SHALL have port IRQ_MASK_I in 2*N_PADS, interrupt mask: bit 2i is rise of pad i, bit 2i+1 is fall of pad i.
REQ-009 SHALL have port CLR_I in 2*N_PADS, write-1-to-clear strobe for STS_O, same bit map as IRQ_MASK_I.
REQ-010 SHALL have port PAD_DI_I in N_PADS, DI_O[0] of each pad cell; asynchronous to CLK_I.
REQ-011 SHALL have port IE_O out N_PADS, pad input enable.
REQ-012 SHALL have port STE_O out 2*N_PADS, pad Schmitt-trigger enable, bits [2i+1:2i] for pad i.
REQ-013 SHALL have port LVL_O out N_PADS, debounced pad level.
REQ-014 SHALL have port VLD_O out N_PADS, high when the pad is ACTIVE.
REQ-015 SHALL have port STS_O out 2*N_PADS, sticky edge status.
REQ-016 SHALL have port IRQ_O out 1, registered interrupt.

Function
REQ-017 SHALL run an independent per-pad FSM with states OFF, SETTLE and ACTIVE.
REQ-018 SHALL move OFF->SETTLE on EN_I[i]=1, driving IE_O[i] high from that edge and loading the settle counter with SETTLE_CYC.
REQ-019 SHALL decrement the settle counter in SETTLE and go SETTLE->ACTIVE on the edge where the counter reads 1, so IE_O is high for exactly SETTLE_CYC cycles before VLD_O rises.
REQ-020 SHALL, on the SETTLE->ACTIVE edge, load LVL_O[i] from the synchronised sample without setting STS_O.
REQ-021 SHALL go from any state to OFF on the first edge with EN_I[i]=0: IE_O, VLD_O, LVL_O and the debounce counter clear; STS_O is held.
REQ-022 SHALL drive STE_O[2i+1:2i] with STE_CFG_I registered, for all pads regardless of state.
REQ-023 SHALL pass PAD_DI_I through a 2-flop synchroniser per pad, and the synchroniser SHALL not be reset by EN_I.
REQ-024 SHALL, in ACTIVE, increment the debounce counter each cycle the synchronised sample differs from LVL_O and clear it when they match.
REQ-025 SHALL update LVL_O on the edge where the mismatch has persisted max(DEB_THR_I,1) consecutive cycles, then clear the counter.
REQ-026 SHALL saturate the debounce counter and not wrap; a DEB_THR_I change takes effect on the next compare.
REQ-027 SHALL, on the same edge LVL_O rises (falls) in ACTIVE, set STS_O[2i] (STS_O[2i+1]).
REQ-028 SHALL clear STS_O bits on CLR_I=1; when set and clear coincide on the same bit, set wins.
REQ-029 SHALL register IRQ_O = OR(STS_O & IRQ_MASK_I), one cycle after the STS_O or mask change.
REQ-030 SHALL give a total latency from a PAD_DI_I change to LVL_O of 2 + max(DEB_THR_I,1) cycles, jitter +1 cycle.

Reset
REQ-031 SHALL, while RST_I=1, asynchronously force all FSMs to OFF and all counters, synchroniser flops and outputs to 0; STE_O resets to 2'b00.
REQ-032 SHALL leave OFF on the first CLK_I edge after RST_I deasserts if EN_I is high.

Verification
REQ-033 SHALL cover: EN_I[0] 0->1, SETTLE_CYC=4 -> IE_O[0]=1 at edge n, VLD_O[0]=1 at edge n+4, no STS_O bit set.
REQ-034 SHALL cover: DEB_THR_I=3, pad 0 ACTIVE at level 0, PAD_DI_I[0] held 1 -> LVL_O[0]=1 five cycles later, STS_O[0]=1 on that edge, IRQ_O=1 one cycle later when IRQ_MASK_I[0]=1.
REQ-035 SHALL cover: a 2-cycle high glitch with DEB_THR_I=3 -> LVL_O unchanged and STS_O=0.
REQ-036 SHALL cover: CLR_I[0]=1 on the same edge a new rise is detected -> STS_O[0] stays 1.
REQ-037 SHALL cover: EN_I[0] dropped mid-debounce -> IE_O, LVL_O and VLD_O=0 next edge; re-enable repeats the full SETTLE.
REQ-038 SHALL cover: RST_I asserted mid-SETTLE, asynchronous to CLK_I -> all outputs 0 immediately, and SETTLE restarts after release.
